fuzz_vector_player: RTL and testbench

//  Synthesizable successor to the fuzz-harness stimulus loop. Replays a loaded table of packed

---
 rtl/fuzz_vector_player.sv | 164 ++++++++++++++++
 tb/tb_fuzz_vector_player.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_vector_player.sv
// fuzz_vector_player: replays a loaded vector table into a fuzzed DUT,
// streams each capture out and folds it into a MISR signature.
module fuzz_vector_player #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 166,
  parameter int DEPTH = 32,
  parameter int HOLD  = 2,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [IN_W-1:0]            cfg_wdata,
  input  logic [$clog2(DEPTH):0]     num_vec,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [IN_W-1:0]            dut_in,
  input  logic [OUT_W-1:0]           dut_out,
  output logic                       cap_valid,
  input  logic                       cap_ready,
  output logic [$clog2(DEPTH)-1:0]   cap_index,
  output logic [OUT_W-1:0]           cap_data,
  input  logic [SIG_W-1:0]           expected_sig,
  output logic [SIG_W-1:0]           signature,
  output logic                       match
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int NS = (OUT_W + SIG_W - 1) / SIG_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [IN_W-1:0] mem [DEPTH];
  logic [AW-1:0]   v;
  logic [NW-1:0]   n_lat;
  logic [NW-1:0]   n_sat;
  logic [HW-1:0]   hcnt;
  logic            go;
  logic            last_hold;
  logic            last_vec;
  logic [SIG_W-1:0] sig_nx;

  function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] d);
    logic [NS*SIG_W-1:0] p;
    logic [SIG_W-1:0]    r;
    p = (NS*SIG_W)'(d);
    r = '0;
    for (int i = 0; i < NS; i++) begin
      r = r ^ p[i*SIG_W +: SIG_W];
    end
    return r;
  endfunction

  assign go = start && (state == S_IDLE || state == S_DONE);
  assign last_hold = (hcnt == HW'(HOLD - 1));
  assign last_vec = ({1'b0, v} == n_lat - NW'(1));
  assign n_sat = (num_vec == '0 || num_vec > NW'(DEPTH))
               ? NW'(DEPTH) : num_vec;

  assign sig_nx = {signature[SIG_W-2:0], 1'b0}
                ^ (signature[SIG_W-1] ? POLY : '0)
                ^ fold(cap_data);

  assign busy = (state == S_PRIME) || (state == S_APPLY)
             || (state == S_CAPTURE);
  assign done = (state == S_DONE);

  // Table is loadable only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (cfg_we && state == S_IDLE) begin
      mem[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (go) state_nx = S_PRIME;
      S_PRIME:   state_nx = S_APPLY;
      S_APPLY:   if (last_hold) state_nx = S_CAPTURE;
      S_CAPTURE: begin
        if (cap_ready) begin
          state_nx = last_vec ? S_DONE : S_APPLY;
        end
      end
      S_DONE:    if (go) state_nx = S_PRIME;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in    <= '0;
      cap_data  <= '0;
      cap_index <= '0;
      cap_valid <= 1'b0;
      signature <= '0;
      match     <= 1'b0;
      v         <= '0;
      n_lat     <= '0;
      hcnt      <= '0;
    end else if (go) begin
      n_lat     <= n_sat;
      signature <= '0;
      v         <= '0;
      match     <= 1'b0;
      dut_in    <= '0;
      hcnt      <= '0;
    end else begin
      unique case (state)
        S_PRIME: begin
          dut_in <= mem[v];
          hcnt   <= '0;
        end
        S_APPLY: begin
          if (last_hold) begin
            cap_valid <= 1'b1;
            cap_data  <= dut_out;
            cap_index <= v;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        S_CAPTURE: begin
          if (cap_ready) begin
            cap_valid <= 1'b0;
            signature <= sig_nx;
            hcnt      <= '0;
            // match is only meaningful once the final fold lands
            if (last_vec) begin
              match <= (sig_nx == expected_sig);
            end else begin
              v      <= v + AW'(1);
              dut_in <= mem[v + AW'(1)];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_vector_player.sv
// tb_fuzz_vector_player: randomized table runs against a
// behavioural table/MISR model, plus directed reset and stall cases.
module tb_fuzz_vector_player;

  localparam int IN_W  = 64;
  localparam int OUT_W = 166;
  localparam int DEPTH = 32;
  localparam int SIG_W = 32;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [4:0]        cfg_addr;
  logic [IN_W-1:0]   cfg_wdata;
  logic [5:0]        num_vec;
  logic              start;
  logic              busy;
  logic              done;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              cap_valid;
  logic              cap_ready;
  logic [4:0]        cap_index;
  logic [OUT_W-1:0]  cap_data;
  logic [SIG_W-1:0]  expected_sig;
  logic [SIG_W-1:0]  signature;
  logic              match;

  bit                mode;
  logic [IN_W-1:0]   tbl [DEPTH];
  int                total = 0;
  int                passed = 0;

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] dut_fn(input logic [IN_W-1:0] x,
                                              input bit m);
    if (!m) return OUT_W'(x);
    return {~x[37:0], x ^ 64'hA5A5_5A5A_0F0F_F0F0, {x[31:0], x[63:32]}};
  endfunction

  assign dut_out = dut_fn(dut_in, mode);

  fuzz_vector_player dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .num_vec(num_vec), .start(start),
    .busy(busy), .done(done),
    .dut_in(dut_in), .dut_out(dut_out),
    .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_index(cap_index), .cap_data(cap_data),
    .expected_sig(expected_sig), .signature(signature), .match(match)
  );

  function automatic logic [31:0] m_fold(input logic [OUT_W-1:0] d);
    logic [191:0] p;
    logic [31:0]  r;
    p = {26'b0, d};
    r = 0;
    for (int i = 0; i < 6; i++) r = r ^ p[32*i +: 32];
    return r;
  endfunction

  function automatic logic [31:0] m_misr(input logic [31:0] s,
                                         input logic [OUT_W-1:0] d);
    logic [31:0] t;
    t = s << 1;
    if (s[31]) t = t ^ POLY;
    return t ^ m_fold(d);
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input int a, input logic [IN_W-1:0] d);
    cfg_we = 1'b1;
    cfg_addr = 5'(a);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run(input int nv, input int stall_i, input int stall_n,
                     input bit wr0, input logic [IN_W-1:0] wd0,
                     input bit poke, output logic [31:0] sig,
                     output int cyc);
    int n;
    int k;
    logic [31:0] m;
    logic [OUT_W-1:0] e;
    n = (nv == 0 || nv > DEPTH) ? DEPTH : nv;
    num_vec = 6'(nv);
    start = 1'b1;
    if (wr0) begin
      cfg_we = 1'b1;
      cfg_addr = 5'd0;
      cfg_wdata = wd0;
      tbl[0] = wd0;
    end
    @(negedge clk);
    start = 1'b0;
    cfg_we = 1'b0;
    cyc = 0;
    m = 0;
    sig = 0;
    chk("prime_busy", busy, 1);
    chk("prime_done", done, 0);
    chk("prime_din", dut_in, 0);
    chk("prime_sig", signature, 0);
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!cap_valid && k < 16) begin
        @(negedge clk);
        cyc++;
        k++;
      end
      chk("cap_timeout", cap_valid, 1);
      if (!cap_valid) return;
      e = dut_fn(tbl[i], mode);
      chk("cap_idx", cap_index, i);
      chk("cap_data", cap_data, e);
      if (i == stall_i) begin
        cap_ready = 1'b0;
        if (poke) start = 1'b1;
        repeat (stall_n) begin
          @(negedge clk);
          cyc++;
          start = 1'b0;
        end
        chk("stall_valid", cap_valid, 1);
        chk("stall_idx", cap_index, i);
        chk("stall_data", cap_data, e);
        chk("stall_din", dut_in, tbl[i]);
        cap_ready = 1'b1;
      end
      m = m_misr(m, e);
      @(negedge clk);
      cyc++;
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", cap_valid, 0);
    chk("end_sig", signature, m);
    chk("end_match", match, m == expected_sig);
    sig = m;
  endtask

  initial begin
    logic [31:0] s21;
    logic [31:0] s;
    int cyc;
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    num_vec = '0;
    start = 1'b0;
    cap_ready = 1'b1;
    expected_sig = '0;
    mode = 1'b0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", cap_valid, 0);
    chk("rst_din", dut_in, 0);
    chk("rst_sig", signature, 0);
    chk("rst_match", match, 0);
    chk("rst_idx", cap_index, 0);
    chk("rst_cdata", cap_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // passthrough, single vector
    tbl[0] = 64'h1;
    wr(0, 64'h1);
    run(1, -1, 0, 1'b0, '0, 1'b0, s, cyc);
    chk("t2_latency", cyc, 4);
    chk("t2_sig", signature, 32'h1);
    chk("t2_cap", cap_data, 166'h1);

    // restart straight from DONE
    run(1, -1, 0, 1'b0, '0, 1'b0, s, cyc);

    // randomized table, scrambling DUT
    mode = 1'b1;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i] = {$urandom, $urandom};
      wr(i, tbl[i]);
    end
    run(21, -1, 0, 1'b0, '0, 1'b0, s21, cyc);
    run(0, -1, 0, 1'b0, '0, 1'b0, s, cyc);
    run(40, -1, 0, 1'b0, '0, 1'b0, s, cyc);
    run(8, 1, 5, 1'b0, '0, 1'b1, s, cyc);
    run(DEPTH, 30, 3, 1'b0, '0, 1'b1, s, cyc);

    // golden signature compare
    expected_sig = s21;
    run(21, -1, 0, 1'b0, '0, 1'b0, s, cyc);
    chk("t5_match_hi", match, 1);
    wr(3, ~tbl[3]);
    do_reset();
    run(21, -1, 0, 1'b0, '0, 1'b0, s, cyc);
    chk("t5_ignored_wr", match, 1);
    do_reset();
    tbl[5] = tbl[5] ^ (64'h1 << 17);
    wr(5, tbl[5]);
    run(21, 4, 2, 1'b0, '0, 1'b0, s, cyc);
    chk("t5_match_lo", match, 0);

    // write alongside start lands before the run reads it
    do_reset();
    run(4, -1, 0, 1'b1, {$urandom, $urandom}, 1'b0, s, cyc);

    // reset in the middle of the second vector
    do_reset();
    num_vec = 6'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t1_pre_busy", busy, 1);
    chk("t1_pre_sig", signature, m_misr(0, dut_fn(tbl[0], mode)));
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t1_busy", busy, 0);
    chk("t1_valid", cap_valid, 0);
    chk("t1_din", dut_in, 0);
    chk("t1_sig", signature, 0);
    chk("t1_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
